// File: rtl/retire_unit_if.sv
// Shared core types plus the retire unit's bundled ports: ROB commit bus in,
// freed-tag handshake out, flush/recovery controls and the committed alias table.
package core_pkg;
    localparam int ISSUE_WIDTH = 2;
    localparam int ROB_ENTRIES = 16;
    localparam int PREG_W      = 6;

    typedef logic [PREG_W-1:0] preg_tag_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } retire_state_e;
endpackage

interface retire_unit_if #(
    parameter int ROB_SIZE = core_pkg::ROB_ENTRIES
);
    import core_pkg::*;

    localparam int PTR_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

    logic [ISSUE_WIDTH-1:0]      commit_valid;
    logic [ISSUE_WIDTH-1:0][4:0] commit_arch_rd;
    preg_tag_t [ISSUE_WIDTH-1:0] commit_phys_rd;
    logic [ISSUE_WIDTH-1:0]      commit_exception;

    // free_valid/free_ready: a tag transfers on a posedge where both are high;
    // while free_valid && !free_ready, free_tag holds its value.
    logic                        free_valid;
    preg_tag_t                   free_tag;
    logic                        free_ready;
    logic                        free_almost_full;
    logic                        overflow_err;

    logic                        flush_en;
    logic [PTR_W-1:0]            flush_ptr;
    logic                        recover_busy;
    preg_tag_t [31:0]            crat_map;
    retire_state_e               state_dbg;

    modport master (
        output commit_valid, commit_arch_rd, commit_phys_rd, commit_exception,
        output free_ready,
        input  free_valid, free_tag, free_almost_full, overflow_err,
        input  flush_en, flush_ptr, recover_busy, crat_map, state_dbg
    );

    modport slave (
        input  commit_valid, commit_arch_rd, commit_phys_rd, commit_exception,
        input  free_ready,
        output free_valid, free_tag, free_almost_full, overflow_err,
        output flush_en, flush_ptr, recover_busy, crat_map, state_dbg
    );
endinterface

// File: rtl/retire_unit.sv
// Commit-side consumer of the ROB: maintains the committed alias table, returns
// freed physical tags through a small FIFO and raises the exception flush.
module retire_unit
    import core_pkg::*;
#(
    parameter int ROB_SIZE   = ROB_ENTRIES,
    parameter int FREE_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    retire_unit_if.slave rt_if
);
    localparam int PTR_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int SUM_W = $clog2(ROB_SIZE + ISSUE_WIDTH) + 1;
    localparam int NC_W  = $clog2(ISSUE_WIDTH + 1);
    localparam int FP_W  = $clog2(FREE_DEPTH);
    localparam int CNT_W = FP_W + 1;

    localparam logic [SUM_W-1:0] ROB_SIZE_S = SUM_W'(ROB_SIZE);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FREE_DEPTH);

    retire_state_e state_q, state_d;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] flush_ptr_q, flush_ptr_d;
    preg_tag_t [31:0] crat_q, crat_d;
    logic             overflow_q, overflow_d;

    preg_tag_t        mem_q [FREE_DEPTH];
    logic [FP_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FP_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ISSUE_WIDTH-1:0]           push_valid;
    preg_tag_t [ISSUE_WIDTH-1:0]      push_tag;
    logic                             exc_seen;
    logic [NC_W-1:0]                  n_commit;
    logic [SUM_W-1:0]                 head_sum;
    logic [PTR_W-1:0]                 head_next;

    logic                             pop;
    logic [CNT_W-1:0]                 free_slots;
    logic [CNT_W-1:0]                 n_acc;
    logic [ISSUE_WIDTH-1:0]           acc;
    logic [ISSUE_WIDTH-1:0][FP_W-1:0] wr_idx;
    logic                             drop;

    logic flush_en;
    logic recover_busy;

    // Commit slots in ascending order; an exception squashes every later slot.
    always_comb begin : commit_comb
        crat_d     = crat_q;
        push_valid = '0;
        push_tag   = '0;
        exc_seen   = 1'b0;
        n_commit   = '0;
        if (state_q == ST_RUN) begin
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
                if (rt_if.commit_valid[j]) begin
                    n_commit      = n_commit + NC_W'(1);
                    push_valid[j] = 1'b1;
                    if (exc_seen || rt_if.commit_exception[j] ||
                        rt_if.commit_arch_rd[j] == 5'd31) begin
                        push_tag[j] = rt_if.commit_phys_rd[j];
                    end else begin
                        push_tag[j] = crat_d[rt_if.commit_arch_rd[j]];
                        crat_d[rt_if.commit_arch_rd[j]] = rt_if.commit_phys_rd[j];
                    end
                    exc_seen = exc_seen | rt_if.commit_exception[j];
                end
            end
        end
    end

    // ROB_SIZE >= ISSUE_WIDTH, so one conditional subtract is a full modulo.
    always_comb begin : head_comb
        head_sum = SUM_W'(head_q) + SUM_W'(n_commit);
        if (head_sum >= ROB_SIZE_S) begin
            head_sum = head_sum - ROB_SIZE_S;
        end
        head_next = head_sum[PTR_W-1:0];

        head_d      = head_q;
        flush_ptr_d = flush_ptr_q;
        case (state_q)
            ST_RUN: begin
                head_d = head_next;
                if (exc_seen) begin
                    flush_ptr_d = head_next;
                end
            end
            ST_FLUSH: head_d = flush_ptr_q;
            default:  head_d = head_q;
        endcase
    end

    // Same-cycle pop frees a slot before the pushes are admitted.
    always_comb begin : fifo_comb
        pop        = (count_q != '0) && rt_if.free_ready;
        free_slots = DEPTH_C - count_q + {{FP_W{1'b0}}, pop};
        n_acc      = '0;
        acc        = '0;
        wr_idx     = '0;
        drop       = 1'b0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            if (push_valid[j]) begin
                if (n_acc < free_slots) begin
                    acc[j]    = 1'b1;
                    wr_idx[j] = wr_ptr_q + n_acc[FP_W-1:0];
                    n_acc     = n_acc + CNT_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        count_d    = count_q + n_acc - {{FP_W{1'b0}}, pop};
        wr_ptr_d   = wr_ptr_q + n_acc[FP_W-1:0];
        rd_ptr_d   = rd_ptr_q + {{(FP_W-1){1'b0}}, pop};
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (exc_seen) state_d = ST_FLUSH;
            ST_FLUSH:   state_d = ST_RECOVER;
            ST_RECOVER: if (count_q == '0) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_comb begin : output_comb
        flush_en     = 1'b0;
        recover_busy = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                flush_en     = 1'b1;
                recover_busy = 1'b1;
            end
            ST_RECOVER: recover_busy = 1'b1;
            default: begin
                flush_en     = 1'b0;
                recover_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin : data_reg
        if (!reset_n) begin
            head_q      <= '0;
            flush_ptr_q <= '0;
            overflow_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < 32; i++) begin
                crat_q[i] <= preg_tag_t'(i);
            end
        end else begin
            head_q      <= head_d;
            flush_ptr_q <= flush_ptr_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            crat_q      <= crat_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : fifo_mem
        if (!reset_n) begin
            mem_q <= '{default: '0};
        end else begin
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
                if (acc[j]) begin
                    mem_q[wr_idx[j]] <= push_tag[j];
                end
            end
        end
    end

    assign rt_if.free_valid       = (count_q != '0);
    assign rt_if.free_tag         = mem_q[rd_ptr_q];
    assign rt_if.free_almost_full = ((DEPTH_C - count_q) < CNT_W'(2));
    assign rt_if.overflow_err     = overflow_q;
    assign rt_if.flush_en         = flush_en;
    assign rt_if.flush_ptr        = flush_ptr_q;
    assign rt_if.recover_busy     = recover_busy;
    assign rt_if.crat_map         = crat_q;
    assign rt_if.state_dbg        = state_q;
endmodule
